// File: rtl/t08_spi_pkg.sv
// rtl/t08_spi_pkg.sv - shared types, constants and helpers for the display SPI transmitter
package t08_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    PARAM = 2'd2,
    DONE  = 2'd3
  } spi_state_t;

  localparam int MAX_PARAM_BYTES = 4;

  // MMIO register addresses for the command and parameter registers
  localparam int SPI_ADDRESS_C = 121212;
  localparam int SPI_ADDRESS_P = 333333;

  // Parameter counts above the register width of the panel protocol saturate
  function automatic logic [2:0] clamp_count(input logic [3:0] cnt);
    return (cnt > 4'(MAX_PARAM_BYTES)) ? 3'(MAX_PARAM_BYTES) : cnt[2:0];
  endfunction

  // Byte idx of the right-justified parameter word (idx 0 = least significant)
  function automatic logic [7:0] param_byte(input logic [31:0] params, input logic [1:0] idx);
    return params[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/t08_spi_if.sv
// rtl/t08_spi_if.sv - MMIO-side command interface and panel pins of the SPI transmitter
interface t08_spi_if;
  logic [7:0]  spi_command_i;
  logic [3:0]  spi_counter_i;
  logic [31:0] spi_parameters_i;
  logic        spi_write_i;
  logic        spi_enable_i;
  logic        spi_busy_o;
  logic        spi_sck_o;
  logic        spi_mosi_o;
  logic        spi_cs_n_o;
  logic        spi_dc_o;

  modport master (
    output spi_command_i, spi_counter_i, spi_parameters_i, spi_write_i, spi_enable_i,
    input  spi_busy_o, spi_sck_o, spi_mosi_o, spi_cs_n_o, spi_dc_o
  );

  modport slave (
    input  spi_command_i, spi_counter_i, spi_parameters_i, spi_write_i, spi_enable_i,
    output spi_busy_o, spi_sck_o, spi_mosi_o, spi_cs_n_o, spi_dc_o
  );
endinterface

// File: rtl/t08_spi_bitclk.sv
// rtl/t08_spi_bitclk.sv - SCK divider: low half then high half per bit, with bit-end strobe
module t08_spi_bitclk #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sck,
  output logic bit_end
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          phase;
  logic          half_end;

  // phase 0 is the SCK-low half of a bit, phase 1 the high half
  assign half_end = run && (div_cnt == HALF_LAST);
  assign bit_end  = half_end && phase;
  assign sck      = phase;

  // Divider restarts from the low half whenever the shifter is not running
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/t08_spi.sv
// rtl/t08_spi.sv - write-only mode-0 SPI transmitter for the display panel (command + params)
module t08_spi #(
  parameter int CLK_DIV = 2
) (
  input  logic      clk,
  input  logic      rst,
  t08_spi_if.slave  bus
);
  import t08_spi_pkg::*;

  spi_state_t  state;
  logic [7:0]  cmd_stage;
  logic [3:0]  cnt_stage;
  logic [7:0]  shift;
  logic [31:0] params;
  logic [2:0]  nbytes;
  logic [2:0]  bit_cnt;
  logic        busy;
  logic        cs_n;
  logic        dc;
  logic        mosi;
  logic        sck;
  logic        bit_end;
  logic        run;
  logic [2:0]  left_after;
  logic [7:0]  next_byte;

  assign run = (state == CMD) || (state == PARAM);

  t08_spi_bitclk #(.CLK_DIV(CLK_DIV)) u_bitclk (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .sck     (sck),
    .bit_end (bit_end)
  );

  // Bytes still owed after the current one, and the byte that follows it
  always_comb begin
    left_after = nbytes;
    next_byte  = 8'h00;
    if (state == PARAM) begin
      left_after = nbytes - 3'd1;
    end
    if (left_after != 3'd0) begin
      next_byte = param_byte(params, 2'(left_after - 3'd1));
    end
  end

  // Staging register: command writes (enable low) park command and count for the next start
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_stage <= 8'h00;
      cnt_stage <= 4'h0;
    end else if ((bus.spi_command_i != 8'h00) && !bus.spi_enable_i) begin
      cmd_stage <= bus.spi_command_i;
      cnt_stage <= bus.spi_counter_i;
    end
  end

  // Frame sequencer and shifter; MOSI/DC only move at bit boundaries while SCK is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= 8'h00;
      params  <= 32'h0;
      nbytes  <= 3'd0;
      bit_cnt <= 3'd0;
      busy    <= 1'b0;
      cs_n    <= 1'b1;
      dc      <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.spi_write_i && bus.spi_enable_i) begin
            state   <= CMD;
            params  <= bus.spi_parameters_i;
            nbytes  <= clamp_count(cnt_stage);
            mosi    <= cmd_stage[7];
            shift   <= {cmd_stage[6:0], 1'b0};
            bit_cnt <= 3'd0;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            dc      <= 1'b0;
          end
        end
        CMD, PARAM: begin
          if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7) begin
              mosi  <= shift[7];
              shift <= {shift[6:0], 1'b0};
            end else begin
              nbytes <= left_after;
              if (left_after != 3'd0) begin
                state <= PARAM;
                dc    <= 1'b1;
                mosi  <= next_byte[7];
                shift <= {next_byte[6:0], 1'b0};
              end else begin
                state <= DONE;
                cs_n  <= 1'b1;
                dc    <= 1'b0;
                mosi  <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_busy_o = busy;
  assign bus.spi_sck_o  = sck;
  assign bus.spi_mosi_o = mosi;
  assign bus.spi_cs_n_o = cs_n;
  assign bus.spi_dc_o   = dc;

endmodule

// File: tb/tb_t08_spi.sv
// tb/tb_t08_spi.sv - directed table-driven bench for the display SPI transmitter
module tb_t08_spi;

  logic clk = 1'b0;
  logic rst;

  t08_spi_if bus();

  t08_spi #(.CLK_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_stage;
    logic [7:0]  cmd;
    logic [3:0]  cnt;
    logic [31:0] params;
    int          exp_n;
    logic [39:0] exp_bytes;
    int          exp_busy;
  } vec_t;

  vec_t vecs[6];

  int   errors = 0;
  int   checks = 0;
  logic bits[64];
  logic dcs[64];
  int   nbits, busy_cycles, csn_low, sck_high, glitches;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stage(input logic [7:0] cmd, input logic [3:0] cnt);
    @(negedge clk);
    bus.spi_command_i = cmd;
    bus.spi_counter_i = cnt;
    bus.spi_enable_i  = 1'b0;
    bus.spi_write_i   = 1'b0;
    @(negedge clk);
    bus.spi_command_i = 8'h00;
  endtask

  task automatic start(input logic [31:0] p);
    bus.spi_parameters_i = p;
    bus.spi_write_i      = 1'b1;
    bus.spi_enable_i     = 1'b1;
    @(negedge clk);
    bus.spi_write_i      = 1'b0;
    bus.spi_enable_i     = 1'b0;
  endtask

  // Records one frame from the cycle after start until busy drops
  task automatic capture(input int inject_at);
    logic prev_sck;
    logic prev_mosi;
    int   k;
    nbits = 0; busy_cycles = 0; csn_low = 0; sck_high = 0; glitches = 0;
    prev_sck = 1'b0; prev_mosi = 1'b0; k = 0;
    while (bus.spi_busy_o === 1'b1 && k < 4000) begin
      busy_cycles++;
      if (bus.spi_cs_n_o === 1'b0) csn_low++;
      if (bus.spi_sck_o === 1'b1) sck_high++;
      if (bus.spi_sck_o === 1'b1 && !prev_sck && nbits < 64) begin
        bits[nbits] = bus.spi_mosi_o;
        dcs[nbits]  = bus.spi_dc_o;
        nbits++;
      end
      if (bus.spi_sck_o === 1'b1 && prev_sck && bus.spi_mosi_o !== prev_mosi) glitches++;
      prev_sck  = bus.spi_sck_o;
      prev_mosi = bus.spi_mosi_o;
      if (inject_at >= 0) begin
        if (k == inject_at) begin
          bus.spi_parameters_i = 32'h0000_005A;
          bus.spi_write_i      = 1'b1;
          bus.spi_enable_i     = 1'b1;
        end else if (k == inject_at + 1) begin
          bus.spi_write_i   = 1'b0;
          bus.spi_enable_i  = 1'b0;
          bus.spi_command_i = 8'h2B;
          bus.spi_counter_i = 4'd0;
        end else if (k == inject_at + 2) begin
          bus.spi_command_i = 8'h00;
        end
      end
      k++;
      @(negedge clk);
    end
    chk("frame_bounded", 64'(k < 4000), 64'd1);
  endtask

  task automatic compare(input string tag, input int exp_n, input logic [39:0] exp_bytes,
                         input int exp_busy);
    logic [7:0]  got;
    logic [39:0] eb;
    int          dc_bad;
    eb = exp_bytes;
    chk({tag, ".busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    chk({tag, ".csn_low"}, 64'(csn_low), 64'(exp_busy - 1));
    chk({tag, ".sck_high"}, 64'(sck_high), 64'(16 * (exp_n + 1)));
    chk({tag, ".nbits"}, 64'(nbits), 64'(8 * (exp_n + 1)));
    chk({tag, ".mosi_stable"}, 64'(glitches), 64'd0);
    for (int i = 0; i <= exp_n && i < 8; i++) begin
      got = 8'h00;
      dc_bad = 0;
      for (int b = 0; b < 8; b++) begin
        got = {got[6:0], bits[8 * i + b]};
        if (dcs[8 * i + b] !== (i > 0)) dc_bad++;
      end
      chk($sformatf("%s.byte%0d", tag, i), 64'(got), 64'(eb[39 - 8 * i -: 8]));
      chk($sformatf("%s.dc%0d", tag, i), 64'(dc_bad), 64'd0);
    end
    chk({tag, ".idle_after"},
        64'({bus.spi_cs_n_o, bus.spi_sck_o, bus.spi_busy_o, bus.spi_mosi_o, bus.spi_dc_o}),
        64'(5'b10000));
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    if (v.do_stage) stage(v.cmd, v.cnt);
    start(v.params);
    capture(-1);
    compare(tag, v.exp_n, v.exp_bytes, v.exp_busy);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h00, 4'd0,  32'h0000_0000, 0, 40'h00_0000_0000, 33};
    vecs[1] = '{1'b1, 8'h29, 4'd0,  32'h0000_0000, 0, 40'h29_0000_0000, 33};
    vecs[2] = '{1'b1, 8'h2A, 4'd4,  32'h0000_013F, 4, 40'h2A_0000_013F, 161};
    vecs[3] = '{1'b1, 8'h2C, 4'd15, 32'h1122_3344, 4, 40'h2C_1122_3344, 161};
    vecs[4] = '{1'b1, 8'h3A, 4'd2,  32'hAABB_CCDD, 2, 40'h3A_CCDD_0000, 97};
    vecs[5] = '{1'b1, 8'h36, 4'd1,  32'h0000_00A5, 1, 40'h36_A500_0000, 65};

    rst = 1'b1;
    bus.spi_command_i    = 8'h00;
    bus.spi_counter_i    = 4'd0;
    bus.spi_parameters_i = 32'h0;
    bus.spi_write_i      = 1'b0;
    bus.spi_enable_i     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({bus.spi_cs_n_o, bus.spi_sck_o, bus.spi_busy_o, bus.spi_mosi_o, bus.spi_dc_o}),
        64'(5'b10000));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vector(vecs[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Second start mid-frame is ignored; staging during busy feeds the next frame
    stage(8'h2C, 4'd1);
    start(32'h0000_00C3);
    capture(40);
    compare("protect", 1, 40'h2C_C300_0000, 65);
    @(negedge clk);
    start(32'h1234_5678);
    capture(-1);
    compare("restaged", 0, 40'h2B_0000_0000, 33);

    // Reset during the second parameter byte abandons the frame at once
    stage(8'h2A, 4'd4);
    start(32'h0000_013F);
    repeat (75) @(negedge clk);
    chk("pre_reset_busy", 64'(bus.spi_busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_outputs",
        64'({bus.spi_cs_n_o, bus.spi_sck_o, bus.spi_busy_o, bus.spi_mosi_o, bus.spi_dc_o}),
        64'(5'b10000));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 64'({bus.spi_cs_n_o, bus.spi_busy_o}), 64'(2'b10));
    run_vector(vecs[2], "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
